// File: rtl/de1_blinker_pkg.sv
// Shared definitions for the blinker system-ID checker.
package de1_blinker_pkg;

    // Checker sequencer states; explicit values keep the encoding fixed.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRdId = 2'd1,
        StRdTs = 2'd2,
        StFin  = 2'd3
    } sysid_state_e;

    // Word offsets within the system-ID slave.
    localparam logic SYSID_WORD_ID = 1'b0;
    localparam logic SYSID_WORD_TS = 1'b1;

    // Width of the per-read stall counter.
    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/de1_blinker_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words
// and flags whether they match the values this image was built against.
module de1_blinker_sysid_checker
    import de1_blinker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_1337,
    parameter logic [31:0] EXPECTED_TS = 32'h67A3_6B7E,
    parameter bit          AUTO_START  = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    // Abort happens on the stall cycle that sees the counter at this value.
    localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(TIMEOUT_CYC - 1);

    sysid_state_e           state_q, state_d;
    logic                   auto_q, auto_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   id_ok_d, ts_ok_d, timeout_d;
    logic [31:0]            id_value_d, ts_value_d;
    logic                   m_read_d, m_address_d;

    // Status decodes straight from the state register.
    assign busy = (state_q != StIdle);
    assign done = (state_q == StFin);

    // Next-state, capture and bus-strobe logic.
    always_comb begin
        state_d    = state_q;
        auto_d     = auto_q;
        stall_d    = stall_q;
        id_ok_d    = id_ok;
        ts_ok_d    = ts_ok;
        timeout_d  = timeout;
        id_value_d = id_value;
        ts_value_d = ts_value;

        unique case (state_q)
            StIdle: begin
                stall_d = '0;
                if (start || auto_q) begin
                    state_d   = StRdId;
                    auto_d    = 1'b0;
                    id_ok_d   = 1'b0;
                    ts_ok_d   = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            StRdId, StRdTs: begin
                if (!m_waitrequest) begin
                    stall_d = '0;
                    if (state_q == StRdId) begin
                        id_value_d = m_readdata;
                        id_ok_d    = (m_readdata == EXPECTED_ID);
                        state_d    = StRdTs;
                    end else begin
                        ts_value_d = m_readdata;
                        ts_ok_d    = (m_readdata == EXPECTED_TS);
                        state_d    = StFin;
                    end
                end else if (stall_q == STALL_LAST) begin
                    // Captures and match flags are left as they stand.
                    timeout_d = 1'b1;
                    state_d   = StFin;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Registered strobes follow the state being entered, so they are
        // stable for the whole time a read is stalled.
        m_read_d    = (state_d == StRdId) || (state_d == StRdTs);
        m_address_d = (state_d == StRdTs) ? SYSID_WORD_TS : SYSID_WORD_ID;
    end

    // State, counter, bus strobes and sticky status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            auto_q    <= AUTO_START;
            stall_q   <= '0;
            m_read    <= 1'b0;
            m_address <= 1'b0;
            id_ok     <= 1'b0;
            ts_ok     <= 1'b0;
            timeout   <= 1'b0;
            id_value  <= '0;
            ts_value  <= '0;
        end else begin
            state_q   <= state_d;
            auto_q    <= auto_d;
            stall_q   <= stall_d;
            m_read    <= m_read_d;
            m_address <= m_address_d;
            id_ok     <= id_ok_d;
            ts_ok     <= ts_ok_d;
            timeout   <= timeout_d;
            id_value  <= id_value_d;
            ts_value  <= ts_value_d;
        end
    end

endmodule

// File: tb/tb_de1_blinker_sysid_checker.sv
// Bench for the system-ID checker: two instances (default stall limit and a
// short one), a transaction-level reference model, directed cases and a
// randomized soak.
module tb_de1_blinker_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_1337;
    localparam logic [31:0] EXP_TS = 32'h67A3_6B7E;

    logic        clock;
    logic        reset_n;
    logic        start_s   [2];
    logic        wr        [2];
    logic [31:0] id_word   [2];
    logic [31:0] ts_word   [2];
    logic [31:0] rdata     [2];
    logic        m_address [2];
    logic        m_read    [2];
    logic        busy      [2];
    logic        done      [2];
    logic        id_ok     [2];
    logic        ts_ok     [2];
    logic        timeout   [2];
    logic [31:0] id_value  [2];
    logic [31:0] ts_value  [2];

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Slave: return the word selected by the DUT's address.
    assign rdata[0] = m_address[0] ? ts_word[0] : id_word[0];
    assign rdata[1] = m_address[1] ? ts_word[1] : id_word[1];

    de1_blinker_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .AUTO_START(1'b1), .TIMEOUT_CYC(255)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .start(start_s[0]),
        .m_address(m_address[0]), .m_read(m_read[0]), .m_waitrequest(wr[0]),
        .m_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .id_ok(id_ok[0]),
        .ts_ok(ts_ok[0]), .timeout(timeout[0]), .id_value(id_value[0]),
        .ts_value(ts_value[0])
    );

    de1_blinker_sysid_checker #(
        .EXPECTED_ID(EXP_ID), .EXPECTED_TS(EXP_TS), .AUTO_START(1'b1), .TIMEOUT_CYC(4)
    ) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start_s[1]),
        .m_address(m_address[1]), .m_read(m_read[1]), .m_waitrequest(wr[1]),
        .m_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .id_ok(id_ok[1]),
        .ts_ok(ts_ok[1]), .timeout(timeout[1]), .id_value(id_value[1]),
        .ts_value(ts_value[1])
    );

    // Reference model: a check is "busy" while words 0 and 1 are fetched,
    // word index 2 is the one-cycle wrap-up; stalls counts consecutive stall
    // cycles on the outstanding word and aborts when it reaches the limit.
    typedef struct packed {
        logic        busy;
        logic [1:0]  word;
        logic [31:0] stalls;
        logic        armed;
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic [31:0] idv;
        logic [31:0] tsv;
    } mdl_t;

    mdl_t mdl [2];

    function automatic mdl_t mdl_reset();
        mdl_t r = '0;
        r.armed = 1'b1;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, logic st, logic w, logic [31:0] idw,
                                      logic [31:0] tsw, int unsigned lim);
        mdl_t n = m;
        if (!m.busy) begin
            if (st || m.armed) begin
                n.busy   = 1'b1;
                n.word   = 2'd0;
                n.stalls = 0;
                n.armed  = 1'b0;
                n.id_ok  = 1'b0;
                n.ts_ok  = 1'b0;
                n.tmo    = 1'b0;
            end
        end else if (m.word == 2'd2) begin
            n.busy = 1'b0;
        end else if (w) begin
            n.stalls = m.stalls + 1;
            if (n.stalls == lim) begin
                n.tmo  = 1'b1;
                n.word = 2'd2;
            end
        end else begin
            if (m.word == 2'd0) begin
                n.idv   = idw;
                n.id_ok = (idw == EXP_ID);
            end else begin
                n.tsv   = tsw;
                n.ts_ok = (tsw == EXP_TS);
            end
            n.stalls = 0;
            n.word   = m.word + 2'd1;
        end
        return n;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) mdl[i] <= mdl_reset();
        end else begin
            for (int i = 0; i < 2; i++)
                mdl[i] <= mdl_step(mdl[i], start_s[i], wr[i], id_word[i], ts_word[i],
                                   (i == 0) ? 255 : 4);
        end
    end

    task automatic cmp(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] t=%0t got=%h want=%h", nm, i, $time, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                cmp("busy", i, busy[i], mdl[i].busy);
                cmp("done", i, done[i], mdl[i].busy && mdl[i].word == 2'd2);
                cmp("m_read", i, m_read[i], mdl[i].busy && mdl[i].word != 2'd2);
                if (mdl[i].busy && mdl[i].word != 2'd2)
                    cmp("m_address", i, m_address[i], mdl[i].word == 2'd1);
                cmp("id_ok", i, id_ok[i], mdl[i].id_ok);
                cmp("ts_ok", i, ts_ok[i], mdl[i].ts_ok);
                cmp("timeout", i, timeout[i], mdl[i].tmo);
                cmp("id_value", i, id_value[i], mdl[i].idv);
                cmp("ts_value", i, ts_value[i], mdl[i].tsv);
            end
        end
    end

    task automatic pulse_start(input int i);
        @(negedge clock);
        start_s[i] = 1'b1;
        @(negedge clock);
        start_s[i] = 1'b0;
    endtask

    // Counts negedges until done is seen on instance i, bounded by limit.
    task automatic wait_done(input int i, input int limit, output int n);
        n = 0;
        while (1) begin
            @(negedge clock);
            n++;
            if (done[i]) break;
            if (n >= limit) begin
                cmp("wait_done_bound", i, 32'd0, 32'd1);
                break;
            end
        end
    endtask

    initial begin
        int n;
        int pulses;
        reset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            wr[i]      = 1'b0;
            id_word[i] = EXP_ID;
            ts_word[i] = EXP_TS;
        end
        repeat (3) @(negedge clock);
        cmp_en = 1'b1;
        cmp("rst_busy", 0, busy[0], 1'b0);
        cmp("rst_m_read", 0, m_read[0], 1'b0);
        cmp("rst_id_value", 0, id_value[0], 32'd0);

        // Auto check after reset release, zero wait states.
        reset_n = 1'b1;
        wait_done(0, 20, n);
        cmp("auto_done_lat", 0, n, 32'd3);
        cmp("auto_done_other", 1, done[1], 1'b1);
        cmp("auto_id_ok", 0, id_ok[0], 1'b1);
        cmp("auto_ts_ok", 0, ts_ok[0], 1'b1);
        cmp("auto_timeout", 0, timeout[0], 1'b0);
        @(negedge clock);
        cmp("auto_idle_after", 0, busy[0], 1'b0);

        // Wrong ID: both words still read.
        id_word[0] = 32'h0000_1338;
        pulse_start(0);
        wait_done(0, 20, n);
        cmp("badid_lat", 0, n + 1, 32'd3);
        cmp("badid_id_ok", 0, id_ok[0], 1'b0);
        cmp("badid_ts_ok", 0, ts_ok[0], 1'b1);
        cmp("badid_id_value", 0, id_value[0], 32'h0000_1338);
        cmp("badid_ts_value", 0, ts_value[0], 32'h67A3_6B7E);
        id_word[0] = EXP_ID;

        // Ten stall cycles on the timestamp word.
        pulse_start(0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            wr[0] = 1'b1;
            cmp("stall_m_read", 0, m_read[0], 1'b1);
            cmp("stall_m_address", 0, m_address[0], 1'b1);
        end
        @(negedge clock);
        wr[0] = 1'b0;
        cmp("stall_m_read_end", 0, m_read[0], 1'b1);
        wait_done(0, 20, n);
        cmp("stall_done_lat", 0, n + 12, 32'd13);
        cmp("stall_ts_ok", 0, ts_ok[0], 1'b1);

        // Stuck waitrequest on the short-limit instance.
        wr[1] = 1'b1;
        pulse_start(1);
        wait_done(1, 20, n);
        cmp("tmo_done_lat", 1, n + 1, 32'd5);
        cmp("tmo_flag", 1, timeout[1], 1'b1);
        cmp("tmo_m_read", 1, m_read[1], 1'b0);
        cmp("tmo_id_ok", 1, id_ok[1], 1'b0);
        wr[1] = 1'b0;
        @(negedge clock);
        cmp("tmo_single_done", 1, done[1], 1'b0);
        cmp("tmo_sticky", 1, timeout[1], 1'b1);

        // New start clears the sticky timeout at its start.
        pulse_start(1);
        cmp("restart_tmo_clr", 1, timeout[1], 1'b0);
        cmp("restart_busy", 1, busy[1], 1'b1);
        wait_done(1, 20, n);
        cmp("restart_lat", 1, n + 1, 32'd3);
        cmp("restart_id_ok", 1, id_ok[1], 1'b1);

        // Start during the timestamp read is ignored.
        pulse_start(0);
        @(negedge clock);
        start_s[0] = 1'b1;
        @(negedge clock);
        start_s[0] = 1'b0;
        pulses = done[0] ? 1 : 0;
        repeat (9) begin
            @(negedge clock);
            pulses += done[0] ? 1 : 0;
        end
        cmp("busy_start_pulses", 0, pulses, 32'd1);

        // Start held high: back-to-back checks with one idle cycle between.
        @(negedge clock);
        start_s[0] = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            if (k == 12) start_s[0] = 1'b0;
            pulses += done[0] ? 1 : 0;
        end
        cmp("held_start_pulses", 0, pulses, 32'd3);

        // Reset during an ID stall.
        repeat (2) @(negedge clock);
        wr[0] = 1'b1;
        pulse_start(0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        cmp("rst_mid_m_read", 0, m_read[0], 1'b0);
        cmp("rst_mid_busy", 0, busy[0], 1'b0);
        cmp("rst_mid_done", 0, done[0], 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        wr[0] = 1'b0;
        wait_done(0, 20, n);
        cmp("rst_rerun_lat", 0, n, 32'd3);
        cmp("rst_rerun_id_ok", 0, id_ok[0], 1'b1);
        cmp("rst_rerun_ts_ok", 0, ts_ok[0], 1'b1);

        // Randomized soak against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) begin
                start_s[i] = ($urandom_range(0, 5) == 0);
                wr[i]      = ($urandom_range(0, 9) < 3);
                id_word[i] = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
                ts_word[i] = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
            end
        end
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            wr[i]      = 1'b0;
        end
        repeat (10) @(negedge clock);
        cmp("drain_busy", 0, busy[0], 1'b0);
        cmp("drain_busy", 1, busy[1], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
